// File: rtl/matrix_op_sequencer.sv
// Walks operand matrices A/B through the external combinational element ALU and writes
// results into C; matrix multiply accumulates inner-product terms before each write.
module matrix_op_sequencer #(
    parameter int DIM_MAX = 5,
    parameter int AW      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [2:0]        size,
    input  logic signed [7:0] scalar,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AW-1:0]     rd_addr_a,
    output logic [AW-1:0]     rd_addr_b,
    input  logic signed [7:0] rd_data_a,
    input  logic signed [7:0] rd_data_b,
    output logic [2:0]        alu_op,
    output logic signed [8:0] alu_a,
    output logic signed [8:0] alu_b,
    output logic [2:0]        alu_size,
    input  logic signed [7:0] alu_result,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [7:0]        wr_data
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MULT = 3'b010,
        OP_SCAL = 3'b011,
        OP_DET  = 3'b100,
        OP_TRAN = 3'b101,
        OP_OPP  = 3'b110,
        OP_CLR  = 3'b111
    } op_t;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_CLEAR, S_DONE} state_t;

    state_t            state;
    op_t               op_q;
    logic [2:0]        size_q;
    logic signed [7:0] scalar_q;
    logic [2:0]        r, c, k;
    logic [7:0]        acc;

    logic [2:0]        last;
    logic              rc_last;
    logic [2:0]        r_nxt, c_nxt;
    logic [7:0]        sum;

    function automatic logic [AW-1:0] addr(input logic [2:0] row, input logic [2:0] col);
        return AW'(int'(row) * DIM_MAX + int'(col));
    endfunction

    assign alu_op   = op_q;
    assign alu_size = size_q;

    // Everything that depends on the storage read data or the ALU result has to be
    // combinational: those inputs only become valid inside the EXEC cycle itself.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        last      = size_q - 3'd1;
        rc_last   = (r == last) && (c == last);
        c_nxt     = (c == last) ? 3'd0 : c + 3'd1;
        r_nxt     = (c == last) ? ((r == last) ? 3'd0 : r + 3'd1) : r;
        sum       = (k == 3'd0) ? alu_result : acc + alu_result;
        rd_addr_a = addr(r, c);
        rd_addr_b = addr(r, c);
        alu_a     = '0;
        alu_b     = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        if (op_q == OP_MULT) begin
            rd_addr_a = addr(r, k);
            rd_addr_b = addr(k, c);
        end
        if (state == S_EXEC) begin
            alu_a = {rd_data_a[7], rd_data_a};
            case (op_q)
                OP_SCAL: alu_b = {scalar_q[7], scalar_q};
                OP_TRAN: alu_b = 9'sd1;
                OP_OPP:  alu_b = -9'sd1;
                default: alu_b = {rd_data_b[7], rd_data_b};
            endcase
            wr_addr = (op_q == OP_TRAN) ? addr(c, r) : addr(r, c);
            if (op_q == OP_MULT) begin
                wr_en   = (k == last);
                wr_data = sum;
            end else begin
                wr_en   = 1'b1;
                wr_data = alu_result;
            end
        end else if (state == S_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = addr(r, c);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= OP_ADD;
            size_q   <= '0;
            scalar_q <= '0;
            r        <= '0;
            c        <= '0;
            k        <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    op_q     <= op_t'(op);
                    size_q   <= size;
                    scalar_q <= scalar;
                    r        <= '0;
                    c        <= '0;
                    k        <= '0;
                    acc      <= '0;
                    busy     <= 1'b1;
                    err      <= 1'b0;
                    if (size < 3'd2 || int'(size) > DIM_MAX || op == OP_DET) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (op == OP_CLR) begin
                        state <= S_CLEAR;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_EXEC;
                S_EXEC: begin
                    if (op_q == OP_MULT) acc <= sum;
                    if (op_q == OP_MULT && k != last) begin
                        k     <= k + 3'd1;
                        state <= S_FETCH;
                    end else begin
                        k <= '0;
                        c <= c_nxt;
                        r <= r_nxt;
                        if (rc_last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_CLEAR: begin
                    c <= c_nxt;
                    r <= r_nxt;
                    if (rc_last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/matrix_op_sequencer.md
# matrix_op_sequencer

Sequences the coprocessor's combinational element ALU over whole matrices. On a start command it walks the operand matrices A and B in the matrix register file. For each element or inner-product term it drives the ALU's op, operand and size inputs, accumulates products for matrix multiply, and writes results into result matrix C. It sits between the host command decoder and the ALU/matrix storage and is the only master of the ALU.

## Interface
Parameters:
- DIM_MAX, 5, maximum matrix dimension; row stride of all matrix storage.
- AW, 5, matrix element address width (covers DIM_MAX*DIM_MAX entries).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset. Sampled on the rising edge of clk; when low, all state and outputs return to reset values.
- start  in  1  command strobe; sampled only in IDLE.
- op  in  3  operation: 000 add, 001 sub, 010 mult, 011 mult-by-scalar, 100 det, 101 transpose, 110 opposite, 111 clear.
- size  in  3  matrix dimension s; valid range 2..DIM_MAX.
- scalar  in  8  signed scalar for op 011.
- busy  out  1  high from the cycle after start is accepted through DONE inclusive.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  valid with done; 1 = command rejected, nothing written.
- rd_addr_a, rd_addr_b  out  AW  read addresses into A and B.
- rd_data_a, rd_data_b  in  8  signed data; registered in storage, so valid one cycle after the address.
- alu_op  out  3  to ALU op.
- alu_a, alu_b  out  9  signed ALU operands.
- alu_size  out  3  latched size.
- alu_result  in  8  signed combinational ALU result.
- wr_en  out  1  C write strobe.
- wr_addr  out  AW  C address.
- wr_data  out  8  C data.

## Operation
- Address of element (r,c) = r*DIM_MAX + c. Row-major, fixed stride regardless of s.
- At start in IDLE: latch op, size and scalar; clear the r, c and k counters and the accumulator.
  - If size < 2, size > DIM_MAX, or op = 100 (det unsupported), go to DONE with err=1.
  - Else if op = 111, go to CLEAR.
  - Else go to FETCH.
- start outside IDLE is ignored. Input changes after acceptance have no effect.
- FETCH: drive read addresses.
  - Element-wise ops (add, sub, scalar, transpose, opposite): rd_addr_a = rd_addr_b = addr(r,c).
  - mult: rd_addr_a = addr(r,k), rd_addr_b = addr(k,c).
  - No write in FETCH. Next state is EXEC.
- EXEC: alu_a = sign-extend(rd_data_a). alu_b is selected by op:
  - add/sub/mult: sign-extend(rd_data_b).
  - 011: sign-extend(scalar).
  - 101: +1.
  - 110: -1.
- EXEC writes (element-wise ops): wr_en=1 and wr_data=alu_result.
  - wr_addr = addr(r,c), except transpose, which uses addr(c,r).
- EXEC writes (mult):
  - sum = (k==0) ? alu_result : acc + alu_result, 8-bit two's-complement wrap.
  - acc <= sum.
  - When k == s-1: wr_en=1, wr_addr=addr(r,c), wr_data=sum. Otherwise no write.
- Counter advance after EXEC:
  - mult: k increments first; at s-1 it wraps to 0 and c increments; c wraps into r.
  - Element-wise ops: c increments, then wraps into r.
  - After the last element/term, go to DONE; otherwise go back to FETCH.
- CLEAR: each cycle wr_en=1, wr_data=0 at addr(r,c), r/c advance. After the last element, go to DONE.
- DONE: done=1, busy=1 for one cycle, then IDLE.
- alu_op always equals the latched op. alu_size always equals the latched size.
- Outside EXEC and CLEAR, wr_en=0.

## Timing
- Reset values:
  - State is IDLE.
  - busy, done, err and wr_en are 0.
  - All addresses, wr_data, alu_a, alu_b, alu_op and alu_size are 0.
  - The accumulator and all counters are 0.
- Cycle numbering: start is sampled at edge 0; FETCH of the first item occurs in cycle 1.
- Element-wise ops: 2*s*s FETCH/EXEC cycles; done in cycle 2*s*s+1.
- mult: done in cycle 2*s*s*s+1.
- clear: s*s writes in cycles 1..s*s; done in cycle s*s+1.
- Rejected command: done=1, err=1 in cycle 1, with no writes.
- Throughput: a new start can be accepted in the cycle after DONE, when the block is back in IDLE.
- rst_n low mid-operation: the block is in IDLE on the next edge. wr_en is 0 from that edge on, no further writes are made, and done is not pulsed.

## Test plan
- add, s=2, A=[1,2,3,4], B=[5,6,7,8] -> C=[6,8,10,12] written in cycles 2,4,6,8; done in cycle 9; err=0.
- mult, s=2, same A and B -> C=[19,22,43,50]; exactly 4 writes; done in cycle 17.
- Wrap: add with A[0]=127, B[0]=1 -> C[0]=-128. Opposite of -128 -> -128 (8-bit wrap).
- transpose, s=3, A=1..9 -> C row-major [1,4,7,2,5,8,3,6,9] at stride-5 addresses; done in cycle 19.
- Rejection: size=1, and separately op=det with size=3 -> done and err in cycle 1, wr_en never asserted. Also clear with s=2 -> 4 zero writes, done in cycle 5.
- start pulsed while busy is ignored. rst_n low in cycle 5 of an s=3 add -> no wr_en after that edge, busy=0, and a following start runs normally.
